// File: rtl/dff_pipe_sync_rst.sv
`default_nettype none
// ============================================================================
// Module      : dff_pipe_sync_rst
// Description : Elastic register pipeline of DEPTH valid-tagged WIDTH-bit
//               stages with valid/ready handshake, bubble collapsing, flush,
//               synchronous reset to RST_VAL and an occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_pipe_sync_rst #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;

    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_in_valid;
    logic [WIDTH-1:0] w_in_data [DEPTH];
    logic [OCC_W-1:0] w_occ;

    // A stage may load when it is empty or everything downstream moves.
    always_comb begin
        logic carry;
        carry = out_ready;
        w_adv = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            carry    = ~r_valid[i] | carry;
            w_adv[i] = carry;
        end
    end

    assign in_ready = w_adv[0] & ~flush & ~reset;

    always_comb begin
        w_in_valid[0] = in_valid & in_ready;
        w_in_data[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_in_valid[i] = r_valid[i-1];
            w_in_data[i]  = r_data[i-1];
        end
    end

    // Data only captures real words, so an empty output keeps its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RST_VAL;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_adv[i]) begin
                    r_valid[i] <= w_in_valid[i];
                    if (w_in_valid[i]) begin
                        r_data[i] <= w_in_data[i];
                    end
                end
            end
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OCC_W'(r_valid[i]);
        end
    end

    assign occupancy = w_occ;
    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_dff_pipe_sync_rst.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_pipe_sync_rst
// Description : Scoreboard bench for dff_pipe_sync_rst, 8x3 and 1x1 configs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_pipe_sync_rst;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit, 3-deep instance
    logic       rst_a, fl_a, iv_a, ir_a, ov_a, ordy_a;
    logic [7:0] id_a, od_a;
    logic [1:0] occ_a;

    // 1-bit, 1-deep instance with a non-zero reset value
    logic       rst_b, fl_b, iv_b, ir_b, ov_b, ordy_b;
    logic [0:0] id_b, od_b;
    logic [0:0] occ_b;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] qa[$];
    logic [0:0] qb[$];
    logic [7:0] exp_a;
    logic [0:0] exp_b;

    dff_pipe_sync_rst #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h00)) u_dut_a (
        .clk(clk), .reset(rst_a), .flush(fl_a),
        .in_valid(iv_a), .in_data(id_a), .in_ready(ir_a),
        .out_valid(ov_a), .out_data(od_a), .out_ready(ordy_a),
        .occupancy(occ_a)
    );

    dff_pipe_sync_rst #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b1)) u_dut_b (
        .clk(clk), .reset(rst_b), .flush(fl_b),
        .in_valid(iv_b), .in_data(id_b), .in_ready(ir_b),
        .out_valid(ov_b), .out_data(od_b), .out_ready(ordy_b),
        .occupancy(occ_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: record accepted words (or discard on reset/flush), then advance.
    task automatic cyc();
        @(negedge clk);
        if (rst_a || fl_a) qa.delete();
        else if (iv_a && ir_a) qa.push_back(id_a);
        if (rst_b || fl_b) qb.delete();
        else if (iv_b && ir_b) qb.push_back(id_b);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_a && !fl_a && ov_a && ordy_a) begin
            vectors++;
            if (qa.size() == 0) begin
                miscompares++;
                $display("FAIL a_out: got unexpected word %h expected none", od_a);
            end else begin
                exp_a = qa.pop_front();
                if (od_a !== exp_a) begin
                    miscompares++;
                    $display("FAIL a_out: got %h expected %h", od_a, exp_a);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b && !fl_b && ov_b && ordy_b) begin
            vectors++;
            if (qb.size() == 0) begin
                miscompares++;
                $display("FAIL b_out: got unexpected word %h expected none", od_b);
            end else begin
                exp_b = qb.pop_front();
                if (od_b !== exp_b) begin
                    miscompares++;
                    $display("FAIL b_out: got %h expected %h", od_b, exp_b);
                end
            end
        end
    end

    initial begin
        rst_a = 1'b1; fl_a = 1'b0; iv_a = 1'b1; id_a = 8'h55; ordy_a = 1'b1;
        rst_b = 1'b1; fl_b = 1'b0; iv_b = 1'b1; id_b = 1'b0; ordy_b = 1'b1;

        // Reset held two cycles with input offered
        cyc();
        cyc();
        chk("a_rst_in_ready", ir_a, 0);
        chk("a_rst_out_valid", ov_a, 0);
        chk("a_rst_out_data", od_a, 8'h00);
        chk("a_rst_occ", occ_a, 0);
        chk("b_rst_in_ready", ir_b, 0);
        chk("b_rst_out_data", od_b, 1);
        rst_a = 1'b0; iv_a = 1'b0;
        rst_b = 1'b0; iv_b = 1'b0;
        #1;
        chk("a_post_rst_in_ready", ir_a, 1);
        chk("b_post_rst_in_ready", ir_b, 1);
        chk("b_post_rst_occ", occ_b, 0);

        // Stream: latency DEPTH-1 edges, one word per cycle
        iv_a = 1'b1; id_a = 8'h11; cyc();
        id_a = 8'h22; cyc();
        id_a = 8'h33; cyc();
        chk("stream_out_k2", od_a, 8'h11);
        chk("stream_valid_k2", ov_a, 1);
        chk("stream_occ_peak", occ_a, 3);
        iv_a = 1'b0;
        cyc();
        chk("stream_out_k3", od_a, 8'h22);
        chk("stream_occ_k3", occ_a, 2);
        cyc();
        chk("stream_out_k4", od_a, 8'h33);
        cyc();
        chk("stream_empty_valid", ov_a, 0);
        chk("stream_empty_hold", od_a, 8'h33);
        chk("stream_empty_occ", occ_a, 0);

        // Backpressure
        ordy_a = 1'b0; iv_a = 1'b1;
        id_a = 8'hA1; cyc();
        id_a = 8'hA2; cyc();
        id_a = 8'hA3; cyc();
        id_a = 8'hA4; #1;
        chk("bp_full_in_ready", ir_a, 0);
        chk("bp_full_occ", occ_a, 3);
        cyc();
        chk("bp_stall_data", od_a, 8'hA1);
        chk("bp_stall_occ", occ_a, 3);
        ordy_a = 1'b1; #1;
        chk("bp_pop_push_in_ready", ir_a, 1);
        cyc();
        chk("bp_pop_push_occ", occ_a, 3);
        chk("bp_pop_push_data", od_a, 8'hA2);
        iv_a = 1'b0;
        cyc(); cyc(); cyc();
        chk("bp_drained_occ", occ_a, 0);

        // Bubble collapse
        ordy_a = 1'b0;
        iv_a = 1'b1; id_a = 8'hB1; cyc();
        iv_a = 1'b0; cyc(); cyc();
        iv_a = 1'b1; id_a = 8'hB2; cyc();
        iv_a = 1'b0;
        chk("bubble_occ", occ_a, 2);
        chk("bubble_head", od_a, 8'hB1);
        cyc();
        chk("bubble_hold_occ", occ_a, 2);
        ordy_a = 1'b1;
        cyc();
        chk("bubble_second", od_a, 8'hB2);
        cyc();
        chk("bubble_empty", ov_a, 0);

        // Flush while full: valids clear, data registers untouched
        ordy_a = 1'b0; iv_a = 1'b1;
        id_a = 8'hC1; cyc();
        id_a = 8'hC2; cyc();
        id_a = 8'hC3; cyc();
        fl_a = 1'b1; id_a = 8'hC4; ordy_a = 1'b1; #1;
        chk("flush_in_ready", ir_a, 0);
        cyc();
        fl_a = 1'b0; iv_a = 1'b0;
        chk("flush_occ", occ_a, 0);
        chk("flush_valid", ov_a, 0);
        chk("flush_data_kept", od_a, 8'hC1);
        iv_a = 1'b1; id_a = 8'hD1; cyc();
        iv_a = 1'b0;
        cyc(); cyc(); cyc();
        chk("flush_after_occ", occ_a, 0);

        // Reset and flush together mid-stream
        ordy_a = 1'b0; iv_a = 1'b1;
        id_a = 8'hE1; cyc();
        id_a = 8'hE2; cyc();
        iv_a = 1'b0; cyc();
        chk("prio_pre_data", od_a, 8'hE1);
        rst_a = 1'b1; fl_a = 1'b1; cyc();
        rst_a = 1'b0; fl_a = 1'b0;
        chk("prio_data", od_a, 8'h00);
        chk("prio_valid", ov_a, 0);
        chk("prio_occ", occ_a, 0);

        // Degenerate 1x1: visible right after accepting edge, pop+push when full
        ordy_b = 1'b1; iv_b = 1'b1;
        id_b = 1'b0; cyc();
        chk("b_first_data", od_b, 0);
        chk("b_first_valid", ov_b, 1);
        chk("b_first_occ", occ_b, 1);
        chk("b_full_pop_ready", ir_b, 1);
        id_b = 1'b1; cyc();
        chk("b_second_data", od_b, 1);
        id_b = 1'b0; cyc();
        chk("b_third_data", od_b, 0);
        ordy_b = 1'b0; id_b = 1'b1; #1;
        chk("b_full_stall_ready", ir_b, 0);
        cyc();
        chk("b_stall_data", od_b, 0);
        rst_b = 1'b1; fl_b = 1'b1; cyc();
        rst_b = 1'b0; fl_b = 1'b0; iv_b = 1'b0;
        chk("b_prio_data", od_b, 1);
        chk("b_prio_valid", ov_b, 0);
        chk("b_prio_occ", occ_b, 0);

        cyc(); cyc();
        chk("a_scoreboard_empty", qa.size(), 0);
        chk("b_scoreboard_empty", qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
